uart_rx_fifo_ctrl: RTL
======================

// Module: uart_rx_fifo_ctrl
// PURPOSE
//  Parametrised circular receive buffer between the UART receiver and the CPU load path.
//  The CPU drives a 2-bit command per cycle: pop, peek or flush.
//  Adds a selectable full policy (overwrite oldest / drop newest), an occupancy count,
//  threshold flags and sticky overflow/underflow flags that software can clear.
// PARAMETERS
//  WIDTH        32            data word width
//  DEPTH        16            entries; power of two, >= 2
//  OVERWRITE    1             1: write when full replaces oldest; 0: write when full is dropped
//  AF_THRESH    DEPTH-2       almost_full asserted when count >= AF_THRESH (1..DEPTH)
//  AE_THRESH    2             almost_empty asserted when count <= AE_THRESH (0..DEPTH-1)
//  EMPTY_VALUE  {WIDTH{1'b1}} data_out value returned for a pop or peek while empty
// PORTS
//  clk           in   1              rising-edge clock
//  reset         in   1              reset, synchronous, active-high
//  write         in   1              push data_in this cycle
//  data_in       in   WIDTH          word to push
//  op            in   2              00 nop, 01 pop, 10 peek, 11 flush
//  clr_flags     in   1              clear sticky overflow/underflow
//  data_out      out  WIDTH          registered read data
//  count         out  $clog2(DEPTH)+1  registered occupancy, 0..DEPTH
//  empty         out  1              count == 0
//  full          out  1              count == DEPTH
//  almost_full   out  1              count >= AF_THRESH
//  almost_empty  out  1              count <= AE_THRESH
//  overflow      out  1              sticky: a write arrived while full (no same-cycle pop)
//  underflow     out  1              sticky: a pop arrived while empty
// BEHAVIOUR
//  - Reset clears write_ptr, read_ptr, count, data_out, overflow and underflow to 0.
//    Buffer contents are not cleared. Status flags follow from count = 0.
//  - All state updates on posedge clk. Status flags are combinational from the registered count.
//  - Read latency: data_out updates on the edge that samples the op. It holds until the next pop or peek.
//  - Pointers wrap from DEPTH-1 to 0. Decisions use count, never pointer comparison.
//  - pop, count != 0: data_out <= mem[read_ptr]; read_ptr advances; count decrements.
//  - pop, count == 0: data_out <= EMPTY_VALUE; underflow <= 1; pointers and count unchanged.
//  - peek: data_out <= mem[read_ptr], or EMPTY_VALUE if count == 0. Pointers unchanged; no underflow.
//  - flush: write_ptr, read_ptr and count <= 0. data_out and sticky flags are unchanged.
//    A same-cycle write is discarded (flush wins).
//  - write, not full, no pop: store at write_ptr; write_ptr advances; count increments.
//  - write + pop, 0 < count < DEPTH: both take effect; count unchanged.
//  - write + pop, count == 0: pop returns EMPTY_VALUE and sets underflow.
//    The write is stored and count becomes 1 (no fall-through).
//  - write + pop, count == DEPTH: pop returns the oldest word; the write stores into the freed slot.
//    count stays DEPTH; overflow is not set.
//  - write, full, no pop, OVERWRITE=1: store at write_ptr; both pointers advance.
//    The oldest word is lost; count stays DEPTH; overflow <= 1.
//  - write, full, no pop, OVERWRITE=0: data discarded; pointers and count unchanged; overflow <= 1.
//  - write + peek, count == 0: peek returns EMPTY_VALUE; the write is stored.
//  - clr_flags clears overflow and underflow. A same-cycle set event wins (flag reads 1).
//  - reset asserted mid-operation overrides every op and write in that cycle.
// TESTING
//  1. Reset, then 3 writes (A,B,C) and 3 pops -> data_out A,B,C on successive edges.
//     count 3->0; then a pop gives data_out=FFFFFFFF and underflow=1.
//  2. DEPTH=16, OVERWRITE=1: write 0..16 (17 words) -> full=1, overflow=1.
//     16 pops return 1..16; count ends 0.
//  3. OVERWRITE=0: write 0..16 -> overflow=1; pops return 0..15; value 16 is never seen.
//  4. Full FIFO, write X with a same-cycle pop -> data_out is the oldest word; count stays 16; overflow stays 0.
//     After 16 more pops, X is the last word out.
//  5. count=5: peek twice -> same word, count 5. Then flush with a same-cycle write -> count 0, empty=1.
//     Then peek -> FFFFFFFF with underflow unchanged.
//  6. Walk count 0..16 -> almost_empty for count <= 2, almost_full for count >= 14.
//     clr_flags with a same-cycle underflow event leaves underflow=1.

Source files
------------

// File: rtl/uart_rx_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_fifo_ctrl
// Purpose  : Circular receive buffer between the UART receiver and the CPU
//            load path. Per-cycle CPU command (nop/pop/peek/flush), selectable
//            full policy (overwrite oldest or drop newest), occupancy count,
//            threshold flags and software-clearable sticky error flags.
// Ports    : clk          - rising-edge clock
//            reset        - synchronous, active-high reset
//            write        - push data_in this cycle
//            data_in      - word to push
//            op           - 00 nop, 01 pop, 10 peek, 11 flush
//            clr_flags    - clear sticky overflow/underflow
//            data_out     - registered read data
//            count        - registered occupancy, 0..DEPTH
//            empty/full   - count == 0 / count == DEPTH
//            almost_full  - count >= AF_THRESH
//            almost_empty - count <= AE_THRESH
//            overflow     - sticky: write while full with no same-cycle pop
//            underflow    - sticky: pop while empty
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_fifo_ctrl #(
  parameter int                 WIDTH       = 32,
  parameter int                 DEPTH       = 16,
  parameter bit                 OVERWRITE   = 1'b1,
  parameter int                 AF_THRESH   = DEPTH - 2,
  parameter int                 AE_THRESH   = 2,
  parameter logic [WIDTH-1:0]   EMPTY_VALUE = {WIDTH{1'b1}}
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       write,
  input  logic [WIDTH-1:0]           data_in,
  input  logic [1:0]                 op,
  input  logic                       clr_flags,
  output logic [WIDTH-1:0]           data_out,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty,
  output logic                       full,
  output logic                       almost_full,
  output logic                       almost_empty,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [1:0] OP_NOP   = 2'b00;
  localparam logic [1:0] OP_POP   = 2'b01;
  localparam logic [1:0] OP_PEEK  = 2'b10;
  localparam logic [1:0] OP_FLUSH = 2'b11;

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_THRESH);
  localparam logic [CW-1:0] AE_C    = CW'(AE_THRESH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    write_ptr;
  logic [AW-1:0]    read_ptr;

  logic is_pop;
  logic is_peek;
  logic is_flush;
  logic is_nop;
  logic has_data;
  logic is_full;
  logic pop_ok;
  logic wr_accept;
  logic evict;
  logic cnt_inc;
  logic overflow_set;
  logic underflow_set;

  always_comb begin
    is_nop   = (op == OP_NOP);
    is_pop   = (op == OP_POP);
    is_peek  = (op == OP_PEEK);
    is_flush = (op == OP_FLUSH);
    has_data = (count != '0);
    is_full  = (count == DEPTH_C);
    pop_ok   = is_pop && has_data;

    // A full buffer accepts a write if a pop frees a slot this cycle, or if
    // the overwrite policy lets the new word displace the oldest one.
    wr_accept = write && !is_flush && (!is_full || pop_ok || OVERWRITE);

    // Overwrite with no pop: the read side must skip the lost word.
    evict = wr_accept && is_full && !is_pop;

    // Count grows only when a word is stored without a matching departure.
    cnt_inc = wr_accept && !evict && !pop_ok;

    // A flush discards the same-cycle write, so it cannot overflow.
    overflow_set  = write && !is_flush && is_full && !is_pop;
    underflow_set = is_pop && !has_data;
  end

  always_ff @(posedge clk) begin
    if (wr_accept) begin
      mem[write_ptr] <= data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      write_ptr <= '0;
      read_ptr  <= '0;
      count     <= '0;
      data_out  <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (is_pop || is_peek) begin
        data_out <= has_data ? mem[read_ptr] : EMPTY_VALUE;
      end

      if (is_flush) begin
        write_ptr <= '0;
        read_ptr  <= '0;
        count     <= '0;
      end else begin
        // Pointer width equals log2(DEPTH), so increment wraps naturally.
        if (wr_accept) begin
          write_ptr <= write_ptr + 1'b1;
        end
        if (pop_ok || evict) begin
          read_ptr <= read_ptr + 1'b1;
        end
        if (cnt_inc) begin
          count <= count + 1'b1;
        end else if (pop_ok && !wr_accept) begin
          count <= count - 1'b1;
        end
      end

      // A set event in the same cycle as clr_flags takes priority.
      if (overflow_set) begin
        overflow <= 1'b1;
      end else if (clr_flags) begin
        overflow <= 1'b0;
      end

      if (underflow_set) begin
        underflow <= 1'b1;
      end else if (clr_flags) begin
        underflow <= 1'b0;
      end
    end
  end

  always_comb begin
    empty        = (count == '0);
    full         = (count == DEPTH_C);
    almost_full  = (count >= AF_C);
    almost_empty = (count <= AE_C);
  end

  // is_nop is decoded for readability of the command set only.
  logic unused_nop;
  assign unused_nop = is_nop;

endmodule
`default_nettype wire
